// File: rtl/event_queue_pkg.sv
// Shared constants and helpers for the RTLola event queue.
package event_queue_pkg;

  localparam int DEFAULT_WIDTH = 64;
  localparam int DEFAULT_DEPTH = 5;

  // What a push does when every slot is already occupied.
  typedef enum logic {
    OVF_REJECT    = 1'b0,  // drop the incoming value
    OVF_OVERWRITE = 1'b1   // evict the oldest entry to make room
  } ovf_policy_e;

  // Bits needed to hold an entry count from 0 up to and including depth.
  function automatic int count_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/event_queue.sv
// Shift-register FIFO buffering stream values between event arrival and
// evaluation. Slot 0 holds the newest entry, slot cursor-1 the oldest, and
// every slot at or beyond cursor reads zero so the window is clean for
// window-based lookups.
module event_queue
  import event_queue_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int DEPTH     = DEFAULT_DEPTH,
  parameter bit OVERWRITE = 1'b0,
  localparam int CW       = count_width(DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    push,
  input  logic                    pop,
  input  logic                    flush,
  input  logic signed [WIDTH-1:0] data,
  output logic                    push_valid,
  output logic                    pop_valid,
  output logic signed [WIDTH-1:0] out,
  output logic                    overflow,
  output logic [DEPTH*WIDTH-1:0]  mem,
  output logic [CW-1:0]           cursor,
  output logic                    full,
  output logic                    empty
);

  localparam ovf_policy_e POLICY = ovf_policy_e'(OVERWRITE);

  typedef logic signed [WIDTH-1:0] word_t;

  word_t         slot   [DEPTH];
  word_t         slot_n [DEPTH];
  word_t         kept   [DEPTH];  // storage after the pop, before the push
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_n;
  logic [CW-1:0] cnt_kept;        // count after the pop, before the push
  logic          push_valid_n;
  logic          pop_valid_n;
  logic          overflow_n;
  word_t         out_n;

  // Next storage, count and strobes: flush first, then pop, then push
  // judged against the post-pop count.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no path
    // leaves one unassigned, which would otherwise infer a latch.
    kept         = slot;
    cnt_kept     = cnt;
    slot_n       = slot;
    cnt_n        = cnt;
    push_valid_n = 1'b0;
    pop_valid_n  = 1'b0;
    overflow_n   = 1'b0;
    out_n        = '0;

    if (flush) begin
      for (int i = 0; i < DEPTH; i++) slot_n[i] = '0;
      cnt_n = '0;
    end else begin
      if (pop && cnt != '0) begin
        // The oldest entry leaves and its slot is zeroed on the same edge.
        for (int i = 0; i < DEPTH; i++) begin
          if (CW'(i) == cnt - CW'(1)) begin
            out_n   = slot[i];
            kept[i] = '0;
          end
        end
        pop_valid_n = 1'b1;
        cnt_kept    = cnt - CW'(1);
      end

      slot_n = kept;
      cnt_n  = cnt_kept;

      // On a full queue under overwrite the shift naturally drops slot
      // DEPTH-1, which is the oldest entry, and the count stays at DEPTH.
      if (push && (cnt_kept < CW'(DEPTH) || POLICY == OVF_OVERWRITE)) begin
        slot_n[0] = data;
        for (int i = 1; i < DEPTH; i++) slot_n[i] = kept[i-1];
        push_valid_n = 1'b1;
        if (cnt_kept < CW'(DEPTH)) cnt_n = cnt_kept + CW'(1);
        else                       overflow_n = 1'b1;
      end
    end
  end

  // Storage, count and output registers; reset wins, then clock enable.
  always_ff @(posedge clk) begin
    // NOTE: the storage is reset too, because the whole window is an output
    // that must read zero in its unused slots straight out of reset.
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) slot[i] <= '0;
      cnt        <= '0;
      push_valid <= 1'b0;
      pop_valid  <= 1'b0;
      overflow   <= 1'b0;
      out        <= '0;
    end else if (!en) begin
      push_valid <= 1'b0;
      pop_valid  <= 1'b0;
      overflow   <= 1'b0;
      out        <= '0;
    end else begin
      slot       <= slot_n;
      cnt        <= cnt_n;
      push_valid <= push_valid_n;
      pop_valid  <= pop_valid_n;
      overflow   <= overflow_n;
      out        <= out_n;
    end
  end

  // Flatten the storage into the debug / lookup window, slot 0 lowest.
  for (genvar g = 0; g < DEPTH; g++) begin : g_window
    assign mem[g*WIDTH +: WIDTH] = slot[g];
  end

  assign cursor = cnt;
  assign full   = (cnt == CW'(DEPTH));
  assign empty  = (cnt == '0);

endmodule

// File: tb/tb_event_queue.sv
// Self-checking bench for event_queue: a reject-policy and an
// overwrite-policy instance share one stimulus stream and are compared
// against a queue-based reference model plus hand-derived expectations.
module tb_event_queue;

  localparam int W = 64;
  localparam int D = 5;

  typedef logic [W-1:0] word_t;
  typedef word_t wq_t[$];

  typedef struct packed {
    logic         pv;
    logic         ppv;
    logic         ov;
    logic [W-1:0] out;
    logic [D*W-1:0] mem;
    logic [2:0]   cursor;
    logic         full;
    logic         empty;
  } exp_t;

  logic clk = 1'b0;
  logic rst, en, push, pop, flush;
  logic signed [W-1:0] data;

  logic           r_pv, r_ppv, r_ov, r_full, r_empty;
  logic [W-1:0]   r_out;
  logic [D*W-1:0] r_mem;
  logic [2:0]     r_cursor;
  logic           o_pv, o_ppv, o_ov, o_full, o_empty;
  logic [W-1:0]   o_out;
  logic [D*W-1:0] o_mem;
  logic [2:0]     o_cursor;

  wq_t  q_rej, q_ovw;
  exp_t exp_rej, exp_ovw;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  event_queue #(.WIDTH(W), .DEPTH(D), .OVERWRITE(1'b0)) u_rej (
    .clk(clk), .rst(rst), .en(en), .push(push), .pop(pop), .flush(flush),
    .data(data), .push_valid(r_pv), .pop_valid(r_ppv), .out(r_out),
    .overflow(r_ov), .mem(r_mem), .cursor(r_cursor), .full(r_full),
    .empty(r_empty)
  );

  event_queue #(.WIDTH(W), .DEPTH(D), .OVERWRITE(1'b1)) u_ovw (
    .clk(clk), .rst(rst), .en(en), .push(push), .pop(pop), .flush(flush),
    .data(data), .push_valid(o_pv), .pop_valid(o_ppv), .out(o_out),
    .overflow(o_ov), .mem(o_mem), .cursor(o_cursor), .full(o_full),
    .empty(o_empty)
  );

  // Reference model: q.front() is the oldest value, q.back() the newest.
  task automatic model_step(ref wq_t q, input bit ovw, input bit r, e, pu,
                            po, fl, input word_t d, output exp_t x);
    x = '0;
    if (r) q.delete();
    else if (e) begin
      if (fl) q.delete();
      else begin
        if (po && q.size() > 0) begin
          x.out = q.pop_front();
          x.ppv = 1'b1;
        end
        if (pu) begin
          if (q.size() < D) begin
            q.push_back(d);
            x.pv = 1'b1;
          end else if (ovw) begin
            void'(q.pop_front());
            q.push_back(d);
            x.pv = 1'b1;
            x.ov = 1'b1;
          end
        end
      end
    end
    x.cursor = 3'(q.size());
    x.full   = (q.size() == D);
    x.empty  = (q.size() == 0);
    for (int i = 0; i < q.size(); i++) x.mem[i*W +: W] = q[q.size()-1-i];
  endtask

  // One clock: drive at the falling edge, let the rising edge sample,
  // advance the model, and return at the next falling edge.
  task automatic cycle(input bit r, e, pu, po, fl, input word_t d);
    rst = r; en = e; push = pu; pop = po; flush = fl; data = d;
    @(posedge clk);
    model_step(q_rej, 1'b0, r, e, pu, po, fl, d, exp_rej);
    model_step(q_ovw, 1'b1, r, e, pu, po, fl, d, exp_ovw);
    @(negedge clk);
  endtask

  task automatic do_push(input word_t d); cycle(0, 1, 1, 0, 0, d); endtask
  task automatic do_pop();                cycle(0, 1, 0, 1, 0, '0); endtask
  task automatic do_pp(input word_t d);   cycle(0, 1, 1, 1, 0, d); endtask
  task automatic do_reset();              cycle(1, 1, 0, 0, 0, '0); endtask

  function automatic logic [D*W-1:0] pack5(input word_t s0, s1, s2, s3, s4);
    return {s4, s3, s2, s1, s0};
  endfunction

  task automatic test_reset();
    do_reset();
    n_tests++;
    if ({r_pv, r_ppv, r_ov, r_out, r_mem, r_cursor, r_full, r_empty} !==
        {3'b000, 64'd0, 320'd0, 3'd0, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_rej: got cursor=%0d full=%b empty=%b out=%h", r_cursor, r_full, r_empty, r_out);
    end
    n_tests++;
    if ({o_pv, o_ppv, o_ov, o_out, o_mem, o_cursor, o_full, o_empty} !==
        {3'b000, 64'd0, 320'd0, 3'd0, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_ovw: got cursor=%0d full=%b empty=%b out=%h", o_cursor, o_full, o_empty, o_out);
    end
  endtask

  task automatic test_fifo_order();
    do_reset();
    do_push(1); do_push(2); do_push(3);
    n_tests++;
    if (r_mem !== pack5(3, 2, 1, 0, 0)) begin
      n_fail++;
      $display("FAIL fifo_window: got %h want 3 2 1 0 0", r_mem);
    end
    do_pop();
    n_tests++;
    if ({r_ppv, r_out, r_cursor} !== {1'b1, 64'd1, 3'd2}) begin
      n_fail++;
      $display("FAIL fifo_pop: got pop_valid=%b out=%0d cursor=%0d want 1 1 2", r_ppv, r_out, r_cursor);
    end
  endtask

  task automatic test_push_pop();
    do_pp(4);
    n_tests++;
    if ({r_out, r_cursor} !== {64'd2, 3'd2}) begin
      n_fail++;
      $display("FAIL pp_first: got out=%0d cursor=%0d want 2 2", r_out, r_cursor);
    end
    do_pp(5);
    n_tests++;
    if ({r_out, r_cursor} !== {64'd3, 3'd2}) begin
      n_fail++;
      $display("FAIL pp_second: got out=%0d cursor=%0d want 3 2", r_out, r_cursor);
    end
    n_tests++;
    if (r_mem !== pack5(5, 4, 0, 0, 0)) begin
      n_fail++;
      $display("FAIL pp_window: got %h want 5 4 0 0 0", r_mem);
    end
  endtask

  task automatic test_empty();
    do_reset();
    do_pop();
    n_tests++;
    if ({r_pv, r_ppv, r_out} !== {2'b00, 64'd0}) begin
      n_fail++;
      $display("FAIL empty_pop: got pv=%b ppv=%b out=%0d want 0 0 0", r_pv, r_ppv, r_out);
    end
    do_pp(7);
    n_tests++;
    if ({r_pv, r_ppv, r_out, r_cursor} !== {2'b10, 64'd0, 3'd1}) begin
      n_fail++;
      $display("FAIL empty_pp: got pv=%b ppv=%b out=%0d cursor=%0d want 1 0 0 1", r_pv, r_ppv, r_out, r_cursor);
    end
    do_pop();
    n_tests++;
    if ({r_ppv, r_out, r_empty} !== {1'b1, 64'd7, 1'b1}) begin
      n_fail++;
      $display("FAIL empty_drain: got ppv=%b out=%0d empty=%b want 1 7 1", r_ppv, r_out, r_empty);
    end
  endtask

  task automatic test_full_policies();
    do_reset();
    for (int i = 1; i <= D; i++) do_push(word_t'(i));
    n_tests++;
    if ({r_full, o_full, r_cursor} !== {2'b11, 3'd5}) begin
      n_fail++;
      $display("FAIL fill: got full=%b/%b cursor=%0d want 1/1 5", r_full, o_full, r_cursor);
    end
    do_push(6);
    n_tests++;
    if ({r_pv, r_ov, r_mem} !== {2'b00, pack5(5, 4, 3, 2, 1)}) begin
      n_fail++;
      $display("FAIL reject_push: got pv=%b ov=%b mem=%h want 0 0 5 4 3 2 1", r_pv, r_ov, r_mem);
    end
    n_tests++;
    if ({o_pv, o_ov, o_mem, o_cursor} !== {2'b11, pack5(6, 5, 4, 3, 2), 3'd5}) begin
      n_fail++;
      $display("FAIL overwrite_push: got pv=%b ov=%b mem=%h cursor=%0d want 1 1 6 5 4 3 2 5", o_pv, o_ov, o_mem, o_cursor);
    end
    do_pp(6);
    n_tests++;
    if ({r_pv, r_out, r_mem} !== {1'b1, 64'd1, pack5(6, 5, 4, 3, 2)}) begin
      n_fail++;
      $display("FAIL reject_full_pp: got pv=%b out=%0d mem=%h want 1 1 6 5 4 3 2", r_pv, r_out, r_mem);
    end
    n_tests++;
    if ({o_pv, o_ov, o_out, o_mem} !== {2'b10, 64'd2, pack5(6, 6, 5, 4, 3)}) begin
      n_fail++;
      $display("FAIL overwrite_full_pp: got pv=%b ov=%b out=%0d mem=%h want 1 0 2 6 6 5 4 3", o_pv, o_ov, o_out, o_mem);
    end
  endtask

  task automatic test_flush_en_rst();
    do_reset();
    do_push(1); do_push(2); do_push(3);
    cycle(0, 1, 1, 0, 1, 9);  // flush with a push pending
    n_tests++;
    if ({r_pv, r_ppv, r_out, r_mem, r_cursor, r_empty} !== {2'b00, 64'd0, 320'd0, 3'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL flush: got pv=%b cursor=%0d mem=%h want 0 0 0", r_pv, r_cursor, r_mem);
    end
    do_push(1); do_push(2);
    cycle(0, 0, 1, 0, 0, 9);  // disabled push
    n_tests++;
    if ({r_pv, r_mem, r_cursor} !== {1'b0, pack5(2, 1, 0, 0, 0), 3'd2}) begin
      n_fail++;
      $display("FAIL enable_hold: got pv=%b mem=%h cursor=%0d want 0 2 1 0 0 0 2", r_pv, r_mem, r_cursor);
    end
    cycle(0, 0, 0, 1, 0, 0);  // disabled pop
    n_tests++;
    if ({r_ppv, r_out, r_cursor} !== {1'b0, 64'd0, 3'd2}) begin
      n_fail++;
      $display("FAIL enable_pop: got ppv=%b out=%0d cursor=%0d want 0 0 2", r_ppv, r_out, r_cursor);
    end
    cycle(1, 1, 1, 1, 0, 9);  // reset beats push+pop
    n_tests++;
    if ({r_pv, r_ppv, r_ov, r_out, r_mem, r_cursor, r_full, r_empty} !==
        {3'b000, 64'd0, 320'd0, 3'd0, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_midop: got pv=%b ppv=%b cursor=%0d out=%0d", r_pv, r_ppv, r_cursor, r_out);
    end
  endtask

  task automatic test_random();
    exp_t obs;
    word_t d;
    for (int n = 0; n < 600; n++) begin
      case ($urandom_range(0, 3))
        0:       d = {$urandom, $urandom};
        1:       d = 64'h8000_0000_0000_0000;
        2:       d = '1;
        default: d = word_t'($urandom_range(0, 255));
      endcase
      cycle($urandom_range(0, 99) < 2, $urandom_range(0, 9) != 0,
            $urandom_range(0, 9) < 6, $urandom_range(0, 9) < 5,
            $urandom_range(0, 99) < 3, d);
      obs = {r_pv, r_ppv, r_ov, r_out, r_mem, r_cursor, r_full, r_empty};
      n_tests++;
      if (obs !== exp_rej) begin
        n_fail++;
        $display("FAIL random_rej cycle %0d: got %h want %h", n, obs, exp_rej);
      end
      obs = {o_pv, o_ppv, o_ov, o_out, o_mem, o_cursor, o_full, o_empty};
      n_tests++;
      if (obs !== exp_ovw) begin
        n_fail++;
        $display("FAIL random_ovw cycle %0d: got %h want %h", n, obs, exp_ovw);
      end
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; push = 1'b0; pop = 1'b0; flush = 1'b0; data = '0;
    @(negedge clk);
    test_reset();
    test_fifo_order();
    test_push_pop();
    test_empty();
    test_full_policies();
    test_flush_en_rst();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/event_queue.md
# event_queue

Parametrised FIFO event queue for the RTLola monitor datapath, buffering stream values between event arrival and evaluation. It generalises the fixed 5-entry, 64-bit queue to configurable width and depth. It adds a selectable overflow policy (reject or overwrite-oldest), a flush input, overflow reporting, and full/empty/count status. The full storage window stays visible for debug and for window-based stream lookups.

## Interface
- `WIDTH`, default 64: data width, signed two's complement.
- `DEPTH`, default 5: number of entries, ≥2.
- `OVERWRITE`, default 0: 0 = reject push when full; 1 = evict oldest on full push.
- `clk` in 1: the single clock. All state changes on its rising edge.
- `rst` in 1: synchronous, active-high reset. Overrides every other input.
- `en` in 1: clock enable. When low, storage and count hold.
- `push` in 1: enqueue request.
- `pop` in 1: dequeue request.
- `flush` in 1: discard all entries.
- `data` in WIDTH: signed value to enqueue.
- `push_valid` out 1: registered strobe, push accepted.
- `pop_valid` out 1: registered strobe, `out` holds a dequeued value.
- `out` out WIDTH: dequeued value, 0 when `pop_valid`=0.
- `overflow` out 1: registered strobe, the oldest entry was evicted (OVERWRITE=1 only).
- `mem` out DEPTH*WIDTH: storage window. Slice i is `mem[i*WIDTH +: WIDTH]`. Slot 0 is newest.
- `cursor` out CW: entry count, 0..DEPTH. CW = clog2(DEPTH+1).
- `full` out 1: `cursor`==DEPTH, combinational from the count register.
- `empty` out 1: `cursor`==0, combinational from the count register.

## Operation
- Storage is a shift register.
  - A push shifts slots i→i+1 and writes `data` into slot 0.
  - The oldest valid entry is slot `cursor`-1.
  - Slots at index ≥`cursor` always read 0; a vacated slot is zeroed in the same edge.
- Per edge with `en`=1 and `rst`=0, evaluation order:
  1. `flush`: clear all slots, `cursor`=0, all strobes 0. `push`/`pop` are ignored that cycle.
  2. pop: if `cursor`>0, `out`=slot[`cursor`-1], `pop_valid`=1, count decrements. Otherwise `pop_valid`=0 and `out`=0.
  3. push: evaluated against the count after step 2.
     - Room available: shift, write, increment, `push_valid`=1.
     - Full and OVERWRITE=0: data dropped, `push_valid`=0, state unchanged by the push.
     - Full and OVERWRITE=1: slot DEPTH-1 is discarded by the shift, count stays DEPTH, `push_valid`=1, `overflow`=1.
- Simultaneous push+pop:
  - On a non-empty queue: the oldest entry leaves, the new entry enters slot 0, count unchanged.
  - On an empty queue: `pop_valid`=0, `push_valid`=1, count becomes 1.
  - On a full queue: always succeeds, never overflows.
- `en`=0: storage and `cursor` hold; `push_valid`, `pop_valid`, `overflow` and `out` are 0 for that cycle.
- Data is stored bit-exact. No arithmetic is performed on values; `cursor` never exceeds DEPTH.

## Timing
- Reset value of every output is 0: all `mem` slots, `cursor`, strobes and `out`. `empty`=1 and `full`=0 during and after reset.
- Reset asserted mid-operation clears the queue at that edge. Any push/pop sampled in the same cycle is lost.
- Latency: inputs are sampled at edge N. Strobes, `out`, `mem` and `cursor` reflect the operation from after edge N until edge N+1.
- Strobes are single-cycle. No handshake stall exists: the producer checks `push_valid` and the consumer checks `pop_valid`.
- A held `push`/`pop` repeats the operation on every enabled edge.

## Structure
- Package `event_queue_pkg` holds:
  - default WIDTH/DEPTH constants;
  - the overflow-policy encoding (`OVF_REJECT`=0, `OVF_OVERWRITE`=1);
  - the count-width helper function.
- Single module with no sub-module. Storage, count register and output registers live in one sequential process; `full`/`empty` are continuous assigns.

## Test plan
All scenarios use DEPTH=5, WIDTH=64.
- Reset, then push 1, 2, 3, then pop. Expected:
  - window after the pushes is `3 2 1 0 0`;
  - the pop gives `pop_valid`=1, `out`=1, `cursor`=2.
- Push+pop of 4 on `3 2`, then of 5. Expected:
  - `out`=2, then `out`=3;
  - window ends `5 4 0 0 0`;
  - `cursor` stays 2.
- Empty queue: pop gives (`push_valid`, `pop_valid`, `out`) = (0, 0, 0). Push+pop of 7 gives (1, 0, 0) and `cursor`=1. The next pop gives `out`=7.
- OVERWRITE=0: push 1–5 to reach `full`=1, then push 6 gives `push_valid`=0 and window `5 4 3 2 1`. A following push+pop of 6 gives `out`=1 and window `6 5 4 3 2`.
- OVERWRITE=1: from a full `5 4 3 2 1`, push 6 gives `push_valid`=1, `overflow`=1, window `6 5 4 3 2`, `cursor`=5.
- Flush with push=1 on a 3-entry queue clears all outputs (`cursor`=0). Then `en`=0 with push=1 leaves the queue unchanged. Then `rst` during push+pop gives all outputs 0.
